i2c_target_rx: RTL and testbench
================================

Name: i2c_target_rx

Overview:
- I2C target (slave) receiver: the far end of our write-only I2C initiator.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches the 7-bit device address, ACKs, and receives a register-address byte followed by data bytes.
- Each data byte is presented as a one-cycle register write strobe.
- Used as an on-chip config target and as a bus-functional responder in initiator testbenches.

Parameters:
- TARGET_ADDR, 7'h39, 7-bit device address matched against address byte bits [7:1]
- SYNC_STAGES, 2, synchroniser flops on scl_in/sda_in (min 2)
- FILTER_LEN, 3, consecutive equal samples required before a filtered line changes (glitch filter)

Ports:
- clock  input  1  system clock, at least 20x SCL rate
- reset  input  1  reset, synchronous, active-low
- scl_in  input  1  bus SCL, asynchronous
- sda_in  input  1  bus SDA, asynchronous
- sda_oe  output  1  1 = pull SDA low (open-drain), 0 = release
- wr_valid  output  1  one-cycle strobe, wr_addr/wr_data valid
- wr_addr  output  8  register address for this write
- wr_data  output  8  register data
- busy  output  1  high from addressed-START to STOP/abort
- rw_err  output  1  one-cycle pulse when a matching address arrives with R/W=1

Behaviour:
- Reset (reset==0 at clock edge): sda_oe=0, wr_valid=0, rw_err=0, busy=0, wr_addr=0, wr_data=0, state=IDLE, synchroniser and filter preset to 1 (idle bus).
- Input path: SYNC_STAGES flops, then FILTER_LEN-deep filter. Filtered scl_f/sda_f lag the pins by SYNC_STAGES+FILTER_LEN cycles. Edges are detected on the filtered signals only.
- START: sda_f falls while scl_f==1. STOP: sda_f rises while scl_f==1. Both are recognised in every state, including mid-byte and during ACK.
  - START (also repeated START): bit counter cleared, next state ADDR.
  - STOP: next state IDLE, busy=0, sda_oe=0 the same cycle.
- Data bits are sampled on scl_f rising edges, MSB first, into an 8-bit shift register. A 4-bit counter counts 0..8.
- States:
  - IDLE: wait for START.
  - ADDR: after 8 bits, compare sr[7:1] with TARGET_ADDR.
    - Match with sr[0]==0: go to ACK_A, busy=1.
    - Match with sr[0]==1: pulse rw_err, go to IGNORE (NACK).
    - Mismatch: go to IGNORE.
  - ACK_A, ACK_R, ACK_D: on the scl_f falling edge that follows bit 8, sda_oe=1. On the next scl_f falling edge (end of the 9th clock), sda_oe=0. Next states: ACK_A->REG, ACK_R->DATA, ACK_D->DATA.
  - REG: after 8 bits, latch the byte as the address pointer, go to ACK_R.
  - DATA: after 8 bits, go to ACK_D. In the cycle sda_oe rises, assert wr_valid=1 with wr_addr=pointer and wr_data=byte. Next cycle: pointer+1, 8-bit wrap 0xFF->0x00.
  - IGNORE: sda_oe held 0; wait for START or STOP.
- sda_oe never changes while scl_f==1, so the target itself never creates a START or STOP.
- A STOP or repeated START arriving mid data byte discards the partial byte: no wr_valid.
- reset asserted mid-transfer releases sda_oe that cycle. After reset the block ignores the bus until the next START.
- wr_valid, rw_err, START and STOP in the same cycle cannot occur; START/STOP take priority over bit sampling.

Decomposition:
- Shared package i2c_pkg: state enum (IDLE, ADDR, ACK_A, REG, ACK_R, DATA, ACK_D, IGNORE), I2C_BYTE_BITS=8, and the R/W bit position constant, also used by the initiator.
- One sub-module: i2c_line_filter, holding the synchroniser, glitch filter and rise/fall edge outputs. It is instantiated twice, once for SCL and once for SDA.

Test Plan:
- Write addr 0x72, reg 0x41, data 0x10, then STOP -> three ACKs, one wr_valid with wr_addr=0x41, wr_data=0x10; busy falls after the STOP.
- Address 0x74 (mismatch) followed by two bytes -> sda_oe stays 0 for the whole transfer, no wr_valid, busy stays 0.
- Address 0x73 (read to our address) -> rw_err pulses once, NACK on the 9th clock, no wr_valid.
- Reg 0xFE, data 0xAA 0xBB 0xCC -> wr_valid three times with addresses 0xFE, 0xFF, 0x00.
- Repeated START after 4 bits of a data byte, then addr 0x72, reg 0x05, data 0x99 -> the partial byte is dropped, then a single write of 0x05<=0x99.
- 1-cycle glitch on SCL during a data bit, then reset pulled low during ACK -> the glitch is filtered (no extra bit counted); sda_oe=0 on the reset cycle and the block stays IDLE until the next START.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target receiver state encoding, byte width and the
// position of the R/W bit within the address byte. Also used by the initiator.
package i2c_pkg;

    localparam int unsigned I2C_BYTE_BITS = 8;
    localparam int unsigned I2C_RW_BIT    = 0;
    localparam int unsigned I2C_CNT_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_A,
        REG,
        ACK_R,
        DATA,
        ACK_D,
        IGNORE
    } i2c_state_e;

endpackage

// File: rtl/i2c_target_rx_line_filter.sv
// Synchroniser plus glitch filter for one open-drain bus line, with registered
// one-cycle rise/fall pulses that coincide with the new filtered level.
// Ports:
//   clock, reset  - system clock, synchronous active-low reset
//   line_in       - asynchronous bus line
//   filt          - filtered level (lags line_in by SYNC_STAGES+FILTER_LEN cycles)
//   rise, fall    - one-cycle pulses when filt changes
// SYNC_STAGES and FILTER_LEN must each be at least 2.
module i2c_line_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic line_in,
    output logic filt,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic [FILTER_LEN-2:0]  hist;
    logic [FILTER_LEN-1:0]  window;
    logic                   all_one;
    logic                   all_zero;

    // Newest synchronised sample plus the previous FILTER_LEN-1 samples.
    assign window   = {hist, sync[SYNC_STAGES-1]};
    assign all_one  = &window;
    assign all_zero = ~|window;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync <= '1;
            hist <= '1;
            filt <= 1'b1;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], line_in};
            hist <= window[FILTER_LEN-2:0];
            rise <= all_one && !filt;
            fall <= all_zero && filt;
            if (all_one) begin
                filt <= 1'b1;
            end else if (all_zero) begin
                filt <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: detects START/STOP, matches the 7-bit address, ACKs,
// receives a register pointer then data bytes, emitting one write strobe per byte.
// Ports:
//   clock, reset        - system clock (>= 20x SCL), synchronous active-low reset
//   scl_in, sda_in      - asynchronous bus lines
//   sda_oe              - 1 pulls SDA low
//   wr_valid            - one-cycle strobe qualifying wr_addr/wr_data
//   wr_addr, wr_data    - register write address/data
//   busy                - addressed transfer in progress
//   rw_err              - one-cycle pulse on a read request to our address
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = 7'h39,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       rw_err
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    i2c_state_e               state;
    logic [I2C_BYTE_BITS-1:0] sr;
    logic [I2C_BYTE_BITS-1:0] ptr;
    logic [I2C_CNT_W-1:0]     cnt;

    logic                     start_c;
    logic                     stop_c;
    logic                     last_bit_c;
    logic [I2C_BYTE_BITS-1:0] byte_c;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clock   (clock),
        .reset   (reset),
        .line_in (scl_in),
        .filt    (scl_f),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clock   (clock),
        .reset   (reset),
        .line_in (sda_in),
        .filt    (sda_f),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    assign start_c    = sda_fall && scl_f;
    assign stop_c     = sda_rise && scl_f;
    // Byte as it will look once the current SCL rising-edge bit is shifted in.
    assign byte_c     = {sr[I2C_BYTE_BITS-2:0], sda_f};
    assign last_bit_c = (cnt == I2C_CNT_W'(I2C_BYTE_BITS - 1));

    // Protocol FSM; all outputs registered. START/STOP override bit handling.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            sr       <= '0;
            ptr      <= '0;
            cnt      <= '0;
            sda_oe   <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            rw_err   <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            rw_err   <= 1'b0;
            if (start_c) begin
                state  <= ADDR;
                cnt    <= '0;
                sda_oe <= 1'b0;
            end else if (stop_c) begin
                state  <= IDLE;
                busy   <= 1'b0;
                sda_oe <= 1'b0;
            end else begin
                case (state)
                    ADDR, REG, DATA: begin
                        if (scl_rise) begin
                            sr  <= byte_c;
                            cnt <= cnt + I2C_CNT_W'(1);
                            if (last_bit_c) begin
                                if (state == ADDR) begin
                                    if (byte_c[I2C_BYTE_BITS-1:1] != TARGET_ADDR) begin
                                        state <= IGNORE;
                                        busy  <= 1'b0;
                                    end else if (byte_c[I2C_RW_BIT]) begin
                                        state  <= IGNORE;
                                        busy   <= 1'b0;
                                        rw_err <= 1'b1;
                                    end else begin
                                        state <= ACK_A;
                                        busy  <= 1'b1;
                                    end
                                end else if (state == REG) begin
                                    ptr   <= byte_c;
                                    state <= ACK_R;
                                end else begin
                                    state <= ACK_D;
                                end
                            end
                        end
                    end
                    ACK_A, ACK_R, ACK_D: begin
                        // First SCL fall after bit 8 drives ACK, the next one releases it.
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                                if (state == ACK_D) begin
                                    wr_valid <= 1'b1;
                                    wr_addr  <= ptr;
                                    wr_data  <= sr;
                                    ptr      <= ptr + 8'd1;
                                end
                            end else begin
                                sda_oe <= 1'b0;
                                cnt    <= '0;
                                state  <= (state == ACK_A) ? REG : DATA;
                            end
                        end
                    end
                    IDLE, IGNORE: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: bit-banged initiator, write scoreboard
// queue checked on every wr_valid strobe, immediate-assertion checks.
module tb_i2c_target_rx;

    localparam int unsigned Q = 10;  // system clocks per quarter SCL period

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       scl   = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       rw_err;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clock = ~clock;

    i2c_target_rx dut (
        .clock    (clock),
        .reset    (reset),
        .scl_in   (scl),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .rw_err   (rw_err)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_e;
    int          oe_cycles   = 0;
    int          busy_cycles = 0;
    int          rw_cnt      = 0;
    int          wr_cnt      = 0;
    int          unexp_cnt   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe pops one expected {addr, data}.
    always @(negedge clock) begin
        if (reset) begin
            if (sda_oe) oe_cycles++;
            if (busy) busy_cycles++;
            if (rw_err) rw_cnt++;
            if (wr_valid) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    unexp_cnt++;
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(mon_e[15:8]));
                    check("wr_data", 32'(wr_data), 32'(mon_e[7:0]));
                end
            end
        end
    end

    task automatic wait_q();
        repeat (Q) @(negedge clock);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl   = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl   = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; wait_q();
        scl   = 1'b1; wait_q(); wait_q();
        scl   = 1'b0; wait_q();
    endtask

    // Same as send_bit but with a one-cycle SCL spike during the low phase.
    task automatic send_bit_glitch(input logic b);
        sda_m = b;
        repeat (4) @(negedge clock);
        scl = 1'b1;
        @(negedge clock);
        scl = 1'b0;
        repeat (5) @(negedge clock);
        scl = 1'b1; wait_q(); wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; wait_q();
        scl   = 1'b1; wait_q();
        ack   = ~sda_line;
        wait_q();
        scl   = 1'b0; wait_q();
    endtask

    logic ack;
    int   acks;
    int   wr0, oe0, busy0, rw0;

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        check("rst_sda_oe",   32'(sda_oe),   0);
        check("rst_wr_valid", 32'(wr_valid), 0);
        check("rst_busy",     32'(busy),     0);
        check("rst_rw_err",   32'(rw_err),   0);
        check("rst_wr_addr",  32'(wr_addr),  0);
        check("rst_wr_data",  32'(wr_data),  0);
        reset = 1'b1;
        wait_q();

        // 1: basic write 0x41 <= 0x10
        wr0 = wr_cnt; acks = 0;
        exp_q.push_back({8'h41, 8'h10});
        i2c_start();
        send_byte(8'h72, ack); acks += int'(ack);
        send_byte(8'h41, ack); acks += int'(ack);
        send_byte(8'h10, ack); acks += int'(ack);
        check("t1_acks", 32'(acks), 3);
        check("t1_busy_before_stop", 32'(busy), 1);
        i2c_stop();
        check("t1_busy_after_stop", 32'(busy), 0);
        check("t1_writes", 32'(wr_cnt - wr0), 1);

        // 2: address mismatch
        wr0 = wr_cnt; oe0 = oe_cycles; busy0 = busy_cycles; acks = 0;
        i2c_start();
        send_byte(8'h74, ack); acks += int'(ack);
        send_byte(8'h12, ack); acks += int'(ack);
        send_byte(8'h34, ack); acks += int'(ack);
        i2c_stop();
        check("t2_acks", 32'(acks), 0);
        check("t2_oe_cycles", 32'(oe_cycles - oe0), 0);
        check("t2_busy_cycles", 32'(busy_cycles - busy0), 0);
        check("t2_writes", 32'(wr_cnt - wr0), 0);

        // 3: read request to our address
        wr0 = wr_cnt; rw0 = rw_cnt;
        i2c_start();
        send_byte(8'h73, ack);
        i2c_stop();
        check("t3_nack", 32'(ack), 0);
        check("t3_rw_err", 32'(rw_cnt - rw0), 1);
        check("t3_writes", 32'(wr_cnt - wr0), 0);

        // 4: auto-increment with pointer wrap
        wr0 = wr_cnt; acks = 0;
        exp_q.push_back({8'hFE, 8'hAA});
        exp_q.push_back({8'hFF, 8'hBB});
        exp_q.push_back({8'h00, 8'hCC});
        i2c_start();
        send_byte(8'h72, ack); acks += int'(ack);
        send_byte(8'hFE, ack); acks += int'(ack);
        send_byte(8'hAA, ack); acks += int'(ack);
        send_byte(8'hBB, ack); acks += int'(ack);
        send_byte(8'hCC, ack); acks += int'(ack);
        i2c_stop();
        check("t4_acks", 32'(acks), 5);
        check("t4_writes", 32'(wr_cnt - wr0), 3);

        // 5: repeated START mid data byte drops the partial byte
        wr0 = wr_cnt;
        exp_q.push_back({8'h05, 8'h99});
        i2c_start();
        send_byte(8'h72, ack);
        send_byte(8'h10, ack);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        i2c_start();
        send_byte(8'h72, ack);
        send_byte(8'h05, ack);
        send_byte(8'h99, ack);
        check("t5_last_ack", 32'(ack), 1);
        i2c_stop();
        check("t5_writes", 32'(wr_cnt - wr0), 1);

        // 6: SCL glitch filtered, then reset during data ACK
        wr0 = wr_cnt;
        exp_q.push_back({8'h20, 8'h5A});
        i2c_start();
        send_byte(8'h72, ack);
        send_byte(8'h20, ack);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_bit_glitch(1'b1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        check("t6_ack_driven", 32'(sda_oe), 1);
        check("t6_write", 32'(wr_cnt - wr0), 1);
        sda_m = 1'b1;
        reset = 1'b0;
        @(negedge clock);
        check("t6_rst_sda_oe", 32'(sda_oe), 0);
        check("t6_rst_busy", 32'(busy), 0);
        reset = 1'b1;
        wait_q();
        scl = 1'b1; wait_q(); wait_q();
        scl = 1'b0; wait_q();
        wr0 = wr_cnt; oe0 = oe_cycles; busy0 = busy_cycles; acks = 0;
        send_byte(8'hE4, ack); acks += int'(ack);
        send_byte(8'h72, ack); acks += int'(ack);
        i2c_stop();
        check("t6_idle_acks", 32'(acks), 0);
        check("t6_idle_oe", 32'(oe_cycles - oe0), 0);
        check("t6_idle_busy", 32'(busy_cycles - busy0), 0);
        check("t6_idle_writes", 32'(wr_cnt - wr0), 0);

        // Recovery on the next START
        wr0 = wr_cnt;
        exp_q.push_back({8'h30, 8'h77});
        i2c_start();
        send_byte(8'h72, ack);
        send_byte(8'h30, ack);
        send_byte(8'h77, ack);
        i2c_stop();
        check("t6_recover_writes", 32'(wr_cnt - wr0), 1);

        wait_q();
        check("sb_empty", 32'(exp_q.size()), 0);
        check("unexpected_writes", 32'(unexp_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
